fat_sector_buffer_reader: RTL

//  Drain side of the FAT sector ping-pong buffer (256 x 32-bit RAM, two 128-word halves = one 512-byte sector each).

---
 rtl/fat_sector_buffer_reader_pkg.sv | 27 ++
 rtl/fat_sector_buffer_reader_unpacker.sv | 28 ++
 rtl/fat_sector_buffer_reader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fat_sector_buffer_reader_pkg.sv
// Shared types and constants for the FAT sector buffer drain path.
// Holds the FSM encoding, one-hot half codes and the byte nibble-swap helper.
package fat_sector_buffer_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_RD_ADDR   = 3'd2,
    ST_RD_WAIT   = 3'd3,
    ST_EMIT      = 3'd4,
    ST_HALF_DONE = 3'd5
  } state_t;

  localparam logic [1:0] HALF_LO = 2'b01;
  localparam logic [1:0] HALF_HI = 2'b10;

  localparam int SECTOR_WORDS = 128;

  function automatic logic [7:0] nibble_swap(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction

  function automatic logic [1:0] half_onehot(input logic half);
    return half ? HALF_HI : HALF_LO;
  endfunction

endpackage

// File: rtl/fat_sector_buffer_reader_unpacker.sv
// Combinational byte-lane select of a 32-bit RAM word, little-endian lane order,
// with optional nibble swap to undo the constructor's packing.
module fat_word_unpacker
  import fat_sector_buffer_reader_pkg::*;
#(
  parameter bit SWAP_NIBBLES = 1'b1
) (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  output logic [7:0]  data
);

  logic [7:0] raw;

  always_comb begin
    raw = word[7:0];
    case (lane)
      2'd0: raw = word[7:0];
      2'd1: raw = word[15:8];
      2'd2: raw = word[23:16];
      2'd3: raw = word[31:24];
      default: raw = word[7:0];
    endcase
  end

  assign data = SWAP_NIBBLES ? nibble_swap(raw) : raw;

endmodule

// File: rtl/fat_sector_buffer_reader.sv
// Drains one 128-word half of the sector ping-pong RAM as 512 LE bytes, then requests the other half.
// First byte 3 cycles after the half is granted, >= 6 cycles per word; DATA_READY low freezes the current byte.
module fat_sector_buffer_reader
  import fat_sector_buffer_reader_pkg::*;
#(
  parameter int WORDS_PER_HALF = SECTOR_WORDS,
  parameter int ADDR_W         = 8,
  parameter bit SWAP_NIBBLES   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENA,
  output logic              RENA_SR,
  output logic [ADDR_W-1:0] RADDR_SR,
  input  logic [31:0]       OUTPUT_SR,
  input  logic [1:0]        BUFREADY,
  output logic [1:0]        BUFWAITING,
  output logic [7:0]        DATA_OUT,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic              SECTOR_START,
  output logic              SECTOR_END,
  output logic [15:0]       SECTOR_COUNT
);

  localparam int WORD_W = ADDR_W - 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_HALF - 1);

  state_t            state;
  state_t            state_nxt;
  logic              half;
  logic [WORD_W-1:0] word;
  logic [1:0]        lane;
  logic [31:0]       hold;
  logic [15:0]       count;
  logic [1:0]        waiting;
  logic [7:0]        lane_byte;
  logic              clear;
  logic              emit_last;

  assign clear     = RST || !ENA;
  assign emit_last = DATA_READY && (lane == 2'd3);

  always_ff @(posedge CLK) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (ENA) state_nxt = ST_REQ;
      // Only an exact match of the requested half releases the read; 00, 11 or the wrong half all wait.
      ST_REQ:       if (BUFREADY == waiting) state_nxt = ST_RD_ADDR;
      ST_RD_ADDR:   state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:   state_nxt = ST_EMIT;
      ST_EMIT: begin
        if (emit_last) begin
          state_nxt = (word == LAST_WORD) ? ST_HALF_DONE : ST_RD_ADDR;
        end
      end
      ST_HALF_DONE: state_nxt = ST_REQ;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      half    <= 1'b0;
      word    <= '0;
      lane    <= '0;
      hold    <= '0;
      count   <= '0;
      waiting <= '0;
    end else begin
      // The request is refreshed only on entry to REQ, so it stays stable for the whole read.
      if (state_nxt == ST_REQ && state != ST_REQ) begin
        waiting <= half_onehot((state == ST_HALF_DONE) ? ~half : half);
      end
      case (state)
        ST_RD_WAIT: begin
          hold <= OUTPUT_SR;
          lane <= '0;
        end
        ST_EMIT: begin
          if (DATA_READY) begin
            lane <= lane + 2'd1;
            if (lane == 2'd3 && word != LAST_WORD) begin
              word <= word + WORD_W'(1);
            end
          end
        end
        ST_HALF_DONE: begin
          count <= count + 16'd1;
          half  <= ~half;
          word  <= '0;
        end
        default: ;
      endcase
    end
  end

  fat_word_unpacker #(
    .SWAP_NIBBLES(SWAP_NIBBLES)
  ) u_unpacker (
    .word(hold),
    .lane(lane),
    .data(lane_byte)
  );

  assign RENA_SR      = (state == ST_RD_ADDR);
  assign RADDR_SR     = RENA_SR ? {half, word} : '0;
  assign DATA_VALID   = (state == ST_EMIT);
  assign DATA_OUT     = DATA_VALID ? lane_byte : 8'h00;
  assign BUFWAITING   = waiting;
  assign SECTOR_COUNT = count;
  assign SECTOR_START = DATA_VALID && (word == '0) && (lane == 2'd0);
  assign SECTOR_END   = DATA_VALID && (word == LAST_WORD) && (lane == 2'd3);

endmodule
